usb_bus_bridge: RTL and testbench



---
 rtl/usb_bus_bridge_pkg.sv | 17 +
 rtl/usb_bus_bridge_strobe_fall_det.sv | 27 ++
 rtl/usb_bus_bridge.sv | 168 ++++++++++++++++
 tb/tb_usb_bus_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bus_bridge_pkg.sv
// Shared definitions for the SAM3U host-bus to register-bank bridge.
package usb_bus_bridge_pkg;

    // Default bus geometry: 10-bit host address split into a 5-bit register
    // number and a 5-bit byte index within the register.
    localparam int DEF_ADDR_WIDTH   = 10;
    localparam int DEF_BYTECNT_SIZE = 5;

    // Host strobes are active-low, so their idle (deasserted) level is 1.
    localparam logic STROBE_IDLE = 1'b1;

    // High-to-low transition of an active-low strobe between two samples.
    function automatic logic fell(input logic now_level, input logic prev_level);
        return !now_level && prev_level;
    endfunction

endpackage

// File: rtl/usb_bus_bridge_strobe_fall_det.sv
// Registers one active-low host strobe and flags its falling edge.
module usb_bus_bridge_strobe_fall_det
    import usb_bus_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic level_r,
    output logic fall
);

    logic prev_r;

    // Sample the pin once, keep the previous sample; idle high out of reset so no false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= STROBE_IDLE;
            prev_r  <= STROBE_IDLE;
        end else begin
            level_r <= strobe_n;
            prev_r  <= level_r;
        end
    end

    assign fall = fell(level_r, prev_r);

endmodule

// File: rtl/usb_bus_bridge.sv
// Host parallel bus to byte-wide register-bank bridge: latches the address,
// sequences reads (with the bank's one-cycle latency) and writes, and
// optionally auto-increments the byte index after each completed access.
module usb_bus_bridge
    import usb_bus_bridge_pkg::*;
#(
    parameter int pADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int pBYTECNT_SIZE = DEF_BYTECNT_SIZE,
    parameter bit pAUTO_INC     = 1'b1
) (
    input  logic                               usb_clk,
    input  logic                               reset,
    input  logic [pADDR_WIDTH-1:0]             usb_addr,
    input  logic [7:0]                         usb_din,
    output logic [7:0]                         usb_dout,
    output logic                               usb_isout,
    input  logic                               usb_rdn,
    input  logic                               usb_wrn,
    input  logic                               usb_cen,
    input  logic                               usb_alen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
    output logic                               reg_addrvalid,
    output logic                               reg_read,
    output logic                               reg_write,
    output logic [7:0]                         write_data,
    input  logic [7:0]                         read_data,
    output logic                               bus_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_CAP  = 3'd2,
        ST_RD_HOLD = 3'd3,
        ST_WR_STB  = 3'd4,
        ST_WR_HOLD = 3'd5
    } state_t;

    state_t                   state;
    logic [pADDR_WIDTH-1:0]   addr_r;
    logic [7:0]               din_r;
    logic                     cen_r;
    logic                     alen_r;
    logic                     rdn_r;
    logic                     wrn_r;
    logic                     rd_fall;
    logic                     wr_fall;
    logic                     strobe_fall;

    usb_bus_bridge_strobe_fall_det u_rdn_det (
        .clk      (usb_clk),
        .rst      (reset),
        .strobe_n (usb_rdn),
        .level_r  (rdn_r),
        .fall     (rd_fall)
    );

    usb_bus_bridge_strobe_fall_det u_wrn_det (
        .clk      (usb_clk),
        .rst      (reset),
        .strobe_n (usb_wrn),
        .level_r  (wrn_r),
        .fall     (wr_fall)
    );

    // A strobe only matters to us when the chip is selected.
    assign strobe_fall = !cen_r && (rd_fall || wr_fall);

    // Register the remaining host inputs once so the FSM sees a clean, synchronous view.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            addr_r <= '0;
            din_r  <= '0;
            cen_r  <= STROBE_IDLE;
            alen_r <= STROBE_IDLE;
        end else begin
            addr_r <= usb_addr;
            din_r  <= usb_din;
            cen_r  <= usb_cen;
            alen_r <= usb_alen;
        end
    end

    // Access sequencer: address latch, read/write strobes, host pad drive and byte auto-increment.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            write_data    <= '0;
            usb_dout      <= '0;
            usb_isout     <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            reg_read  <= 1'b0;
            reg_write <= 1'b0;

            // Deselecting the chip invalidates the latched address, whatever state we are in.
            if (cen_r) begin
                reg_addrvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!alen_r && !cen_r) begin
                        reg_address   <= addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt   <= addr_r[pBYTECNT_SIZE-1:0];
                        reg_addrvalid <= 1'b1;
                    end
                    if (strobe_fall) begin
                        if (!reg_addrvalid) begin
                            // Selected but no address latched: drop the access.
                            bus_err <= 1'b1;
                        end else if (wr_fall) begin
                            // Write wins a simultaneous read/write; the read is dropped and flagged.
                            state      <= ST_WR_STB;
                            reg_write  <= 1'b1;
                            write_data <= din_r;
                            if (rd_fall) begin
                                bus_err <= 1'b1;
                            end
                        end else begin
                            state    <= ST_RD_REQ;
                            reg_read <= 1'b1;
                        end
                    end
                end
                ST_RD_REQ: begin
                    state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    // Bank data is valid now, one cycle after the request.
                    state     <= ST_RD_HOLD;
                    usb_dout  <= read_data;
                    usb_isout <= 1'b1;
                end
                ST_RD_HOLD: begin
                    if (rdn_r) begin
                        state     <= ST_IDLE;
                        usb_isout <= 1'b0;
                        if (pAUTO_INC) begin
                            reg_bytecnt <= reg_bytecnt + 1'b1;
                        end
                    end
                end
                ST_WR_STB: begin
                    state <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    if (wrn_r) begin
                        state <= ST_IDLE;
                        if (pAUTO_INC) begin
                            reg_bytecnt <= reg_bytecnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_bus_bridge.sv
// Directed plus randomized bench for usb_bus_bridge with a transaction-level reference model.
module tb_usb_bus_bridge;

    localparam int AW = 10;
    localparam int BW = 5;
    localparam int RW = AW - BW;

    logic          usb_clk = 1'b0;
    logic          reset;
    logic [AW-1:0] usb_addr;
    logic [7:0]    usb_din;
    logic [7:0]    usb_dout;
    logic          usb_isout;
    logic          usb_rdn;
    logic          usb_wrn;
    logic          usb_cen;
    logic          usb_alen;
    logic [RW-1:0] reg_address;
    logic [BW-1:0] reg_bytecnt;
    logic          reg_addrvalid;
    logic          reg_read;
    logic          reg_write;
    logic [7:0]    write_data;
    logic [7:0]    read_data = 8'h00;
    logic          bus_err;

    always #5 usb_clk = ~usb_clk;

    usb_bus_bridge dut (
        .usb_clk       (usb_clk),
        .reset         (reset),
        .usb_addr      (usb_addr),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .usb_rdn       (usb_rdn),
        .usb_wrn       (usb_wrn),
        .usb_cen       (usb_cen),
        .usb_alen      (usb_alen),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_addrvalid (reg_addrvalid),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .write_data    (write_data),
        .read_data     (read_data),
        .bus_err       (bus_err)
    );

    int checks   = 0;
    int failures = 0;

    // Register bank stand-in: returns bank_val one cycle after a read request.
    logic [7:0] bank_val = 8'h00;
    always @(posedge usb_clk) begin
        if (reg_read) read_data <= bank_val;
    end

    // Strobe monitor: counts pulses and high cycles, captures what the bank saw on writes.
    int         wr_pulses = 0;
    int         wr_cycles = 0;
    int         rd_pulses = 0;
    int         rd_cycles = 0;
    logic       prev_w = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0]    seen_wdata;
    logic [RW-1:0] seen_waddr;
    logic [BW-1:0] seen_wbc;
    always @(posedge usb_clk) begin
        prev_w <= reg_write;
        prev_r <= reg_read;
        if (reg_write) begin
            wr_cycles  <= wr_cycles + 1;
            seen_wdata <= write_data;
            seen_waddr <= reg_address;
            seen_wbc   <= reg_bytecnt;
            if (!prev_w) wr_pulses <= wr_pulses + 1;
        end
        if (reg_read) begin
            rd_cycles <= rd_cycles + 1;
            if (!prev_r) rd_pulses <= rd_pulses + 1;
        end
    end

    // Reference model state: what the host believes the bridge holds.
    int m_addr  = 0;
    int m_bc    = 0;
    bit m_valid = 1'b0;
    bit m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge usb_clk);
    endtask

    task automatic do_latch(input logic [AW-1:0] a);
        usb_addr = a;
        usb_alen = 1'b0;
        cyc(1);
        usb_alen = 1'b1;
        cyc(2);
        if (!usb_cen) begin
            m_addr  = int'(a) / 32;
            m_bc    = int'(a) % 32;
            m_valid = 1'b1;
        end
    endtask

    task automatic do_write(input logic [7:0] d);
        int p0 = wr_pulses;
        int c0 = wr_cycles;
        usb_din = d;
        usb_wrn = 1'b0;
        cyc(3);
        usb_wrn = 1'b1;
        cyc(2);
        if (!usb_cen && m_valid) begin
            chk("wr_pulse_count", wr_pulses - p0, 1);
            chk("wr_pulse_width", wr_cycles - c0, 1);
            chk("wr_data", seen_wdata, d);
            chk("wr_address", seen_waddr, m_addr);
            chk("wr_bytecnt", seen_wbc, m_bc);
            m_bc = (m_bc + 1) % 32;
        end else begin
            chk("wr_ignored", wr_pulses - p0, 0);
            if (!usb_cen) m_err = 1'b1;
        end
        chk("wr_bytecnt_after", reg_bytecnt, m_bc);
        chk("wr_bus_err", bus_err, m_err);
    endtask

    task automatic do_read(input logic [7:0] v);
        int p0 = rd_pulses;
        int c0 = rd_cycles;
        bank_val = v;
        usb_rdn  = 1'b0;
        cyc(5);
        if (!usb_cen && m_valid) begin
            chk("rd_pulse_count", rd_pulses - p0, 1);
            chk("rd_pulse_width", rd_cycles - c0, 1);
            chk("rd_dout", usb_dout, v);
            chk("rd_isout_held", usb_isout, 1);
        end else begin
            chk("rd_ignored", rd_pulses - p0, 0);
            chk("rd_isout_idle", usb_isout, 0);
            if (!usb_cen) m_err = 1'b1;
        end
        cyc(1);
        usb_rdn = 1'b1;
        cyc(2);
        if (!usb_cen && m_valid) m_bc = (m_bc + 1) % 32;
        chk("rd_isout_released", usb_isout, 0);
        chk("rd_bytecnt_after", reg_bytecnt, m_bc);
        chk("rd_bus_err", bus_err, m_err);
    endtask

    initial begin
        int p0;
        int r0;
        reset    = 1'b1;
        usb_addr = '0;
        usb_din  = '0;
        usb_rdn  = 1'b1;
        usb_wrn  = 1'b1;
        usb_cen  = 1'b0;
        usb_alen = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        chk("rst_isout", usb_isout, 0);
        chk("rst_dout", usb_dout, 0);
        chk("rst_addrvalid", reg_addrvalid, 0);
        chk("rst_read", reg_read, 0);
        chk("rst_write", reg_write, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_address", reg_address, 0);
        chk("rst_bytecnt", reg_bytecnt, 0);

        // Directed: latch 0x0A1, write 0x5C, read 0xA7.
        do_latch(10'h0A1);
        chk("latch_address", reg_address, 5'h05);
        chk("latch_bytecnt", reg_bytecnt, 5'd1);
        chk("latch_valid", reg_addrvalid, 1);
        do_write(8'h5C);
        chk("first_write_bytecnt", reg_bytecnt, 5'd2);
        do_read(8'hA7);

        // 40 back-to-back writes starting at byte 30 of register 7: wraps 31 -> 0.
        do_latch({5'd7, 5'd30});
        p0 = wr_pulses;
        for (int i = 0; i < 40; i++) do_write(8'($urandom_range(0, 255)));
        chk("burst_pulses", wr_pulses - p0, 40);
        chk("burst_address", reg_address, 5'd7);
        chk("burst_bytecnt", reg_bytecnt, (30 + 40) % 32);

        // Randomized mix of latches, writes and reads.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    do_latch(AW'($urandom_range(0, 1023)));
                    chk("rand_latch_address", reg_address, m_addr);
                    chk("rand_latch_bytecnt", reg_bytecnt, m_bc);
                end
                1: do_write(8'($urandom_range(0, 255)));
                default: do_read(8'($urandom_range(0, 255)));
            endcase
        end

        // rdn and wrn fall together: write only, read dropped, error flagged.
        p0 = wr_pulses;
        r0 = rd_pulses;
        usb_din = 8'h3C;
        usb_wrn = 1'b0;
        usb_rdn = 1'b0;
        cyc(3);
        usb_wrn = 1'b1;
        usb_rdn = 1'b1;
        cyc(2);
        chk("both_write_pulses", wr_pulses - p0, 1);
        chk("both_read_pulses", rd_pulses - r0, 0);
        chk("both_write_data", seen_wdata, 8'h3C);
        m_bc  = (m_bc + 1) % 32;
        m_err = 1'b1;
        chk("both_bus_err", bus_err, 1);
        do_write(8'($urandom_range(0, 255)));
        chk("bus_err_sticky", bus_err, 1);

        // Reset while the bridge is driving the host pad.
        bank_val = 8'h99;
        usb_rdn  = 1'b0;
        cyc(5);
        chk("pre_reset_isout", usb_isout, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_isout", usb_isout, 0);
        chk("async_rst_addrvalid", reg_addrvalid, 0);
        chk("async_rst_bus_err", bus_err, 0);
        chk("async_rst_dout", usb_dout, 0);
        cyc(1);
        reset   = 1'b0;
        usb_rdn = 1'b1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_bc    = 0;
        m_addr  = 0;
        cyc(3);

        // Chip deselected: strobes ignored silently.
        usb_cen = 1'b1;
        cyc(2);
        do_write(8'h11);
        do_read(8'h22);
        chk("cen_high_no_err", bus_err, 0);

        // Selected but no address since reset: strobes ignored and flagged.
        usb_cen = 1'b0;
        cyc(2);
        do_write(8'h33);
        chk("no_addr_err", bus_err, 1);
        do_read(8'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
